// File: rtl/ws2812_rainbow_if.sv
// rtl/ws2812_rainbow_if.sv - LED write port between the pattern source and the ws2812 driver
//
// Purpose: carries one LED update per cycle from a pattern source to the driver.
// Signals:
//   led_num   8   LED index for the current write
//   rgb_data  24  colour as {G, R, B}
//   write     1   one-cycle write strobe
// Modports: master drives the port (pattern source), slave receives it (driver).

interface ws2812_rainbow_if;
  logic [7:0]  led_num;
  logic [23:0] rgb_data;
  logic        write;

  modport master (output led_num, rgb_data, write);
  modport slave  (input  led_num, rgb_data, write);
endinterface

// File: rtl/ws2812_rainbow.sv
// rtl/ws2812_rainbow.sv - scrolling rainbow pattern source for the ws2812 LED write port
//
// Purpose: each frame writes one colour-wheel value per LED (one LED per cycle),
// with the hue spread across the strip, then idles FRAME_TICKS cycles and
// advances the hue offset so the rainbow scrolls.
// Ports:
//   clk         in   system clock
//   reset       in   synchronous, active-high reset
//   enable      in   level; allows new frames to start
//   led_bus     master modport of ws2812_rainbow_if (led_num, rgb_data, write)
//   frame_done  out  one-cycle pulse with the last write of a frame
//   busy        out  high whenever the FSM is not in IDLE
// Build option: define WS2812_GAMMA_EN to square each wheel channel
// ((c*c)>>8) before brightness scaling; latency is unchanged.

module ws2812_rainbow #(
  parameter int NUM_LEDS    = 64,
  parameter int HUE_STEP    = 4,
  parameter int HUE_SPEED   = 1,
  parameter int FRAME_TICKS = 500000,
  parameter int BRIGHTNESS  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  ws2812_rainbow_if.master led_bus,
  output logic             frame_done,
  output logic             busy
);

  localparam logic [7:0]  LAST_IDX = 8'(NUM_LEDS - 1);
  localparam logic [7:0]  STEP8    = 8'(HUE_STEP);
  localparam logic [7:0]  SPEED8   = 8'(HUE_SPEED);
  localparam logic [16:0] BRIGHT17 = 17'(BRIGHTNESS);
  localparam int          TICK_W   = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(FRAME_TICKS - 1);

  typedef enum logic [1:0] {IDLE, FILL, DRAIN, WAIT} state_t;

  state_t            state, next_state;
  logic              issue;
  logic              tick_done;
  logic [7:0]        idx;
  logic [TICK_W-1:0] tick_cnt;
  logic [7:0]        hue_offset;

  // Pipeline stage registers
  logic        s1_valid, s1_last;
  logic [7:0]  s1_idx, s1_h;
  logic        s2_valid, s2_last;
  logic [7:0]  s2_idx;
  logic [23:0] s2_grb;

  // Colour wheel, returned as {G, R, B}. k*3 never exceeds 255, so 8-bit math is exact.
  function automatic logic [23:0] wheel(input logic [7:0] h);
    logic [7:0] k;
    logic [7:0] k3;
    if (h < 8'd85) begin
      k  = h;
      k3 = k + k + k;
      return {k3, 8'd255 - k3, 8'd0};
    end else if (h < 8'd170) begin
      k  = h - 8'd85;
      k3 = k + k + k;
      return {8'd255 - k3, 8'd0, k3};
    end else begin
      k  = h - 8'd170;
      k3 = k + k + k;
      return {8'd0, k3, 8'd255 - k3};
    end
  endfunction

`ifdef WS2812_GAMMA_EN
  function automatic logic [7:0] gamma8(input logic [7:0] c);
    logic [15:0] sq;
    sq = {8'd0, c} * {8'd0, c};
    return 8'(sq >> 8);
  endfunction
`endif

  // BRIGHTNESS of 256 passes the channel through unchanged, hence the 17-bit product.
  function automatic logic [7:0] scale8(input logic [7:0] c);
    logic [16:0] p;
    p = {9'd0, c} * BRIGHT17;
    return 8'(p >> 8);
  endfunction

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    issue      = 1'b0;
    tick_done  = 1'b0;
    case (state)
      IDLE:  if (enable) next_state = FILL;
      FILL: begin
        issue = 1'b1;
        if (idx == LAST_IDX) next_state = DRAIN;
      end
      // The registered frame_done marks the last write leaving the pipeline.
      DRAIN: if (frame_done) next_state = WAIT;
      WAIT: begin
        if (tick_cnt == TICK_LAST) begin
          tick_done  = 1'b1;
          next_state = enable ? FILL : IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Index counter, idle-interval counter and hue offset.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx        <= 8'd0;
      tick_cnt   <= '0;
      hue_offset <= 8'd0;
    end else begin
      if (issue) idx <= (idx == LAST_IDX) ? 8'd0 : idx + 8'd1;
      tick_cnt <= (state == WAIT && !tick_done) ? tick_cnt + 1'b1 : '0;
      if (tick_done) hue_offset <= hue_offset + SPEED8;
    end
  end

  // S1 hue, S2 wheel (+ optional gamma), S3 brightness into the output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid         <= 1'b0;
      s1_last          <= 1'b0;
      s1_idx           <= 8'd0;
      s1_h             <= 8'd0;
      s2_valid         <= 1'b0;
      s2_last          <= 1'b0;
      s2_idx           <= 8'd0;
      s2_grb           <= 24'd0;
      led_bus.write    <= 1'b0;
      led_bus.led_num  <= 8'd0;
      led_bus.rgb_data <= 24'd0;
      frame_done       <= 1'b0;
    end else begin
      s1_valid <= issue;
      s1_last  <= issue && (idx == LAST_IDX);
      s1_idx   <= idx;
      // 8-bit arithmetic gives the modulo-256 hue directly.
      s1_h     <= hue_offset + idx * STEP8;

      s2_valid <= s1_valid;
      s2_last  <= s1_valid && s1_last;
      s2_idx   <= s1_idx;
`ifdef WS2812_GAMMA_EN
      s2_grb   <= {gamma8(wheel(s1_h)[23:16]), gamma8(wheel(s1_h)[15:8]), gamma8(wheel(s1_h)[7:0])};
`else
      s2_grb   <= wheel(s1_h);
`endif

      led_bus.write <= s2_valid;
      frame_done    <= s2_valid && s2_last;
      // Data outputs hold their last value between writes.
      if (s2_valid) begin
        led_bus.led_num  <= s2_idx;
        led_bus.rgb_data <= {scale8(s2_grb[23:16]), scale8(s2_grb[15:8]), scale8(s2_grb[7:0])};
      end
    end
  end

endmodule

// File: doc/ws2812_rainbow.md
# ws2812_rainbow

Animated pattern source feeding the `ws2812` driver's LED write port (`led_num`, `rgb_data`, `write`). Each frame it writes one colour-wheel value per LED, one LED per cycle, and the hue is spread across the strip. It then waits a programmable interval and rotates the hue offset, giving a scrolling rainbow. It replaces the hand-coded colour-cycling counter logic in the top level.

## Interface
- `NUM_LEDS`, 64: LEDs written per frame; valid range 1..256.
- `HUE_STEP`, 4: hue increment between adjacent LEDs, in 8-bit hue units.
- `HUE_SPEED`, 1: hue offset advance per frame.
- `FRAME_TICKS`, 500000: idle cycles between frames; must be ≥ 1.
- `BRIGHTNESS`, 16: channel scale; valid range 1..256; 256 means full scale.

Ports:
- `clk`  in  1  system clock; one clock domain only.
- `reset`  in  1  synchronous, active-high reset.
- `enable`  in  1  level; allows new frames to start.
- `led_num`  out  8  LED index for the current write.
- `rgb_data`  out  24  colour as {G[7:0], R[7:0], B[7:0]}.
- `write`  out  1  one-cycle write strobe to the driver.
- `frame_done`  out  1  one-cycle pulse, coincident with the last write of a frame.
- `busy`  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, FILL, DRAIN, WAIT.
- **IDLE**: moves to FILL on the cycle after `enable`=1 is sampled.
- **FILL**: issues index i = 0..NUM_LEDS-1, one per cycle, into a 3-stage pipeline:
  - S1: h = (hue_offset + i*HUE_STEP) mod 256.
  - S2: colour wheel.
  - S3: brightness scale, then registered outputs.
- After issuing index NUM_LEDS-1, FILL moves to DRAIN.
- **DRAIN**: lasts until the last write has left the pipeline, then moves to WAIT.
- **WAIT**: counts FRAME_TICKS cycles. On expiry:
  - hue_offset ← (hue_offset + HUE_SPEED) mod 256;
  - next state is FILL if `enable`=1, else IDLE.
- Colour wheel, with all arithmetic 8-bit unsigned:
  - h < 85: R = 255−3h, G = 3h, B = 0.
  - 85 ≤ h < 170, with k = h−85: R = 0, G = 255−3k, B = 3k.
  - h ≥ 170, with k = h−170: R = 3k, G = 0, B = 255−3k.
- Scaling: each channel c becomes (c × BRIGHTNESS) >> 8. Use a 17-bit intermediate and keep the low 8 bits of the result.
- `enable` deasserted mid-frame: the current frame and its WAIT complete, then the FSM goes to IDLE.
- hue_offset is held while in IDLE. It is cleared only by reset.

## Timing
- Reset values: `write`=0, `frame_done`=0, `busy`=0, `led_num`=0, `rgb_data`=0. Internal state: hue_offset=0, state=IDLE, pipeline valids cleared.
- Reset asserted mid-frame: no `write` appears from the cycle after `reset` is sampled high, and the in-flight frame is discarded.
- Latency: an index issued in FILL at cycle t appears as `write`=1 with `led_num`=i at cycle t+3.
- Writes within a frame are contiguous: NUM_LEDS consecutive cycles, in ascending `led_num` order.
- First write occurs 4 cycles after the cycle in which IDLE samples `enable`=1.
- `frame_done` is asserted in the same cycle as the write with `led_num`=NUM_LEDS-1.
- WAIT begins the cycle after `frame_done`. The next frame's first FILL cycle follows exactly FRAME_TICKS WAIT cycles.
- Frame period with `enable` held high: NUM_LEDS + 3 + FRAME_TICKS cycles.
- `rgb_data` and `led_num` hold their last values while `write`=0.
- NUM_LEDS=256: the index counter wraps to 0 internally with no extra write.

## Configuration
- `WS2812_GAMMA_EN` defined: after the wheel, each channel c is replaced by (c × c) >> 8 before brightness scaling.
  - Computed inside S2; latency is unchanged.
  - Example: 255 → 254, 128 → 64.
- `WS2812_GAMMA_EN` undefined: wheel output goes straight to scaling.

## Test plan
- Reset, then `enable`=1 with BRIGHTNESS=256, HUE_STEP=4, macro off:
  - first write at the 4th cycle after IDLE samples `enable`: `led_num`=0, `rgb_data`=24'h00_FF_00;
  - next write: `led_num`=1, `rgb_data`=24'h0C_F3_00.
- BRIGHTNESS=16, NUM_LEDS=64, hue 0 → `rgb_data`=24'h00_0F_00:
  - exactly 64 contiguous writes;
  - `frame_done` coincident with `led_num`=63.
- HUE_STEP=85, NUM_LEDS=3, BRIGHTNESS=256 → writes 24'h00_FF_00, 24'hFF_00_00, 24'h00_00_FF.
  - With FRAME_TICKS=10, the next frame starts after exactly 10 WAIT cycles.
  - LED 0 then shows hue 1: 24'h03_FC_00.
- HUE_SPEED=200 over two frames: hue_offset wraps 0 → 200 → 144; LED 0 of frame 3 is checked against the wheel at h=144.
- Reset mid-FILL at `led_num`=20: `write`=0 from the next cycle; the restart after reset begins at `led_num`=0 with hue_offset=0.
- `WS2812_GAMMA_EN` defined, BRIGHTNESS=256: hue 0 → 24'h00_FE_00; h=4 → G=(12×12)>>8=0, R=(243×243)>>8=230 → 24'h00_E6_00.
